// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared bank-state type and default sizing for the rx frame sequencer
package rx_frame_pkg;
    typedef enum logic [1:0] {FREE, FILL, FULL} bank_st_e;
    localparam int FRAME_LEN_DEF   = 113;
    localparam int TIMEOUT_CYC_DEF = 100000;
endpackage

// File: rtl/rx_frame_if.sv
// rx_frame_if: byte input, frame-memory write port and consumer handshake of rx_frame_ctrl
interface rx_frame_if #(parameter int ADDR_W = 8);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;
    logic [7:0]        mem_wdata;
    logic              frame_rdy;
    logic              frame_bank;
    logic              frame_ack;
    logic [7:0]        drop_cnt;
    logic              err_timeout;
    modport master (
        input  byte_valid, byte_data, frame_ack,
        output mem_we, mem_waddr, mem_wdata, frame_rdy, frame_bank, drop_cnt, err_timeout
    );
    modport slave (
        output byte_valid, byte_data, frame_ack,
        input  mem_we, mem_waddr, mem_wdata, frame_rdy, frame_bank, drop_cnt, err_timeout
    );
endinterface

// File: rtl/rx_frame_timeout.sv
// rx_frame_timeout: inter-byte idle counter; expire_o pulses on the TIMEOUT_CYC-th idle cycle
module rx_frame_timeout
    import rx_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_Rx,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // a new byte restarts the count; the counter rests at zero whenever it is not running
    always_comb begin
        expire_o = run_i && !clr_i && cnt_q == CW'(TIMEOUT_CYC - 1);
        cnt_d    = (!run_i || clr_i || expire_o) ? '0 : cnt_q + 1'b1;
    end
    // idle count register
    always_ff @(posedge clk_Rx or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: ping-pong frame sequencer from UART bytes to frame memory with ready/ack hand-off
// Optional feature: define RX_FRAME_TIMEOUT_EN to discard partial frames after TIMEOUT_CYC idle cycles.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk_Rx,
    input  logic       rst_n,
    rx_frame_if.master bus
);
    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W:0]   waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic [7:0]        drop_q, drop_d;
    logic              err_q, err_d;
    logic              wr, last, rel, tmo_expire;

`ifdef RX_FRAME_TIMEOUT_EN
    rx_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk_Rx   (clk_Rx),
        .rst_n    (rst_n),
        .run_i    (bank_q[wr_bank_q] == FILL && wr_ptr_q != '0),
        .clr_i    (bus.byte_valid),
        .expire_o (tmo_expire)
    );
`else
    // partial frames never expire in this build; the limit is referenced only to keep one parameter list
    assign tmo_expire = TIMEOUT_CYC < 0;
`endif

    // writer, reader release and output next-state; the offer uses pre-write bank state so a
    // frame is only offered the cycle after its final memory write
    always_comb begin
        wr          = bus.byte_valid && bank_q[wr_bank_q] != FULL;
        last        = wr_ptr_q == ADDR_W'(FRAME_LEN - 1);
        rel         = bus.frame_ack && frame_rdy_q;
        bank_d      = bank_q;
        if (wr)  bank_d[wr_bank_q] = last ? FULL : FILL;
        if (rel) bank_d[rd_bank_q] = FREE;
        wr_bank_d   = wr_bank_q ^ (wr && last);
        rd_bank_d   = rd_bank_q ^ rel;
        wr_ptr_d    = ((wr && last) || tmo_expire) ? '0 : wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        mem_we_d    = wr;
        waddr_d     = wr ? {wr_bank_q, wr_ptr_q} : waddr_q;
        wdata_d     = wr ? bus.byte_data : wdata_q;
        frame_rdy_d = bank_q[rd_bank_d] == FULL;
        drop_d      = (bus.byte_valid && !wr && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        err_d       = tmo_expire;
    end

    // state and registered outputs
    always_ff @(posedge clk_Rx or negedge rst_n)
        if (!rst_n) begin
            bank_q      <= '{FREE, FREE};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            frame_rdy_q <= 1'b0;
            drop_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            frame_rdy_q <= frame_rdy_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.frame_rdy   = frame_rdy_q;
    assign bus.frame_bank  = rd_bank_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed bench for the ping-pong frame sequencer
module tb_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pulses;
    int   p;

    always #5 clk = ~clk;

    rx_frame_if #(.ADDR_W(8)) bus();

    rx_frame_ctrl #(.FRAME_LEN(113), .ADDR_W(8), .TIMEOUT_CYC(50)) dut (
        .clk_Rx (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] d, input logic [8:0] a);
        send(d);
        chk("wr", {bus.mem_we, bus.mem_waddr, bus.mem_wdata}, {1'b1, a, d});
    endtask

    task automatic send_drop(input logic [7:0] d);
        send(d);
        chk("drop_we", {31'd0, bus.mem_we}, 32'd0);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.frame_rdy,
                bus.frame_bank, bus.drop_cnt, bus.err_timeout};
    endfunction

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.frame_ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", outs(), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 113; i++) send_chk(8'(i), 9'(i));
        chk("rdy_early", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b00);
        @(negedge clk);
        chk("rdy_a", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b10);
        for (int i = 0; i < 113; i++) send_chk(8'(i), 9'h100 + 9'(i));
        chk("bank_b", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b10);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 113; i++) send_drop(8'(i));
        chk("drop113", {24'd0, bus.drop_cnt}, 32'd113);
        for (int i = 0; i < 200; i++) send_drop(8'(i));
        chk("drop255", {24'd0, bus.drop_cnt}, 32'd255);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        bus.frame_ack  = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.frame_ack  = 1'b0;
        chk("sim_we", {31'd0, bus.mem_we}, 32'd0);
        chk("ack1", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b11);
        ack();
        chk("ack2", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b00);
        ack();
        chk("ack_idle", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b00);
        for (int i = 0; i < 113; i++) send_chk(8'(255 - i), 9'(i));
        @(negedge clk);
        chk("rdy_c", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b10);
        ack();
        chk("ack_c", {30'd0, bus.frame_rdy, bus.frame_bank}, 32'b01);
        for (int i = 0; i < 10; i++) send_chk(8'(i + 8'h30), 9'h100 + 9'(i));
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            pulses += int'(bus.err_timeout);
        end
`ifdef RX_FRAME_TIMEOUT_EN
        chk("tmo_pulse", pulses, 32'd1);
        p = 0;
`else
        chk("tmo_pulse", pulses, 32'd0);
        p = 10;
`endif
        for (int i = 0; i < 40; i++) send_chk(8'(i + 16), 9'h100 + 9'(p + i));
        #1 rst_n = 1'b0;
        #1 chk("async_rst", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_chk(8'h77, 9'h000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
